// File: rtl/fifo_clk_en_gen.sv
// fifo_clk_en_gen: waits for a stable PLL lock, then emits per-channel
// programmable one-cycle clock-enable pulses, all phase-aligned on run entry.
module fifo_clk_en_gen #(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned DIV_W     = 8,
  parameter int unsigned LOCK_WAIT = 1024,
  localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              pll_locked,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_phase,
  input  logic              lost_clr,
  output logic [NUM_CH-1:0] en_out,
  output logic              ready,
  output logic              lost_lock,
  output logic              cfg_err
);

  localparam int unsigned STAB_W = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_WAIT - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t              state_q;
  logic [STAB_W-1:0]   stab_q;
  logic                sync1_q;
  logic                sync2_q;
  logic                ready_q;
  logic                lost_q;
  logic                err_q;
  logic [NUM_CH-1:0]   en_q;
  logic [DIV_W-1:0]    div_q   [NUM_CH];
  logic [DIV_W-1:0]    phase_q [NUM_CH];
  logic [DIV_W-1:0]    cnt_q   [NUM_CH];

  logic lock;
  logic run_hold;
  logic ch_ok;
  logic phase_ok;
  logic cfg_ok;

  // Write legality and "stays in RUN across this edge" qualifier.
  assign lock     = sync2_q;
  assign run_hold = (state_q == RUN) && lock;
  assign ch_ok    = (32'(cfg_ch) < NUM_CH);
  assign phase_ok = (cfg_div == '0) || (cfg_phase <= cfg_div);
  assign cfg_ok   = ch_ok && phase_ok;

  // Two-flop synchronizer for the asynchronous PLL lock indication.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pll_locked;
      sync2_q <= sync1_q;
    end
  end

  // Lock-qualification FSM with registered ready and sticky lost-lock flag.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_LOCK;
      stab_q  <= '0;
      ready_q <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      // A loss event later in this block overrides the clear.
      if (lost_clr) lost_q <= 1'b0;
      case (state_q)
        WAIT_LOCK: begin
          stab_q  <= '0;
          ready_q <= 1'b0;
          if (lock) state_q <= STABILIZE;
        end
        STABILIZE: begin
          if (!lock) begin
            state_q <= WAIT_LOCK;
            stab_q  <= '0;
          end else if (stab_q == STAB_LAST) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end else begin
            stab_q <= stab_q + STAB_W'(1);
          end
        end
        RUN: begin
          if (!lock) begin
            state_q <= WAIT_LOCK;
            ready_q <= 1'b0;
            lost_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= WAIT_LOCK;
          stab_q  <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Per-channel config, phase counters and registered enable pulses.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
      en_q  <= '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        div_q[i]   <= '0;
        phase_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      err_q <= cfg_wr && !cfg_ok;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        // Enable is gated by run_hold so a lock loss silences outputs at once.
        en_q[i] <= run_hold && (div_q[i] != '0) && (cnt_q[i] == phase_q[i]);
        if (cfg_wr && cfg_ok && (cfg_ch == CH_W'(i))) begin
          div_q[i]   <= cfg_div;
          phase_q[i] <= cfg_phase;
          cnt_q[i]   <= '0;
        end else if (run_hold && (cnt_q[i] != div_q[i])) begin
          cnt_q[i] <= cnt_q[i] + DIV_W'(1);
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  assign en_out    = en_q;
  assign ready     = ready_q;
  assign lost_lock = lost_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_fifo_clk_en_gen.sv
// Bench for fifo_clk_en_gen: cycle-indexed scoreboard of ready/en_out/lost_lock/cfg_err.
module tb_fifo_clk_en_gen;

  localparam int unsigned NUM_CH    = 3;
  localparam int unsigned DIV_W     = 8;
  localparam int unsigned LOCK_WAIT = 16;
  localparam int BIG = 1 << 30;

  typedef struct packed {
    logic       rdy;
    logic       lost;
    logic       err;
    logic [2:0] en;
  } exp_t;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       cfg_wr;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
  logic [7:0] cfg_phase;
  logic       lost_clr;
  logic [2:0] en_out;
  logic       ready;
  logic       lost_lock;
  logic       cfg_err;

  fifo_clk_en_gen #(
    .NUM_CH   (NUM_CH),
    .DIV_W    (DIV_W),
    .LOCK_WAIT(LOCK_WAIT)
  ) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .pll_locked(pll_locked),
    .cfg_wr    (cfg_wr),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_phase (cfg_phase),
    .lost_clr  (lost_clr),
    .en_out    (en_out),
    .ready     (ready),
    .lost_lock (lost_lock),
    .cfg_err   (cfg_err)
  );

  always #5 refclk = ~refclk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  exp_t exp_q[$];

  // Reference model: cycle c is the interval just after rising edge c.
  int m_run_start, m_run_stop;
  int m_lost_set, m_lost_clr, m_err_c;
  logic m_lost;
  int o_s[3], o_d[3], o_p[3];
  int n_s[3], n_d[3], n_p[3];
  int eff[3];

  function automatic void model_reset();
    m_run_start = BIG;
    m_run_stop  = BIG;
    m_lost_set  = -1;
    m_lost_clr  = -1;
    m_err_c     = -1;
    m_lost      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      o_s[i] = 0; o_d[i] = 0; o_p[i] = 0;
      n_s[i] = 0; n_d[i] = 0; n_p[i] = 0;
      eff[i] = 0;
    end
  endfunction

  function automatic logic [2:0] model_en(int c);
    logic [2:0] r;
    int s, d, p, st;
    r = '0;
    for (int i = 0; i < 3; i++) begin
      if (c >= eff[i]) begin s = n_s[i]; d = n_d[i]; p = n_p[i]; end
      else begin s = o_s[i]; d = o_d[i]; p = o_p[i]; end
      st = (s > m_run_start) ? s : m_run_start;
      if (c >= m_run_start + 1 && c < m_run_stop && d != 0 &&
          c >= st + p + 1 && ((c - st - p - 1) % (d + 1)) == 0)
        r[i] = 1'b1;
    end
    return r;
  endfunction

  // Push the expectation for the coming edge, advance, pop and compare.
  task automatic step();
    exp_t e, g;
    int c;
    c = cyc + 1;
    e.en  = model_en(c);
    e.rdy = (c >= m_run_start) && (c < m_run_stop);
    if (c == m_lost_set) m_lost = 1'b1;
    else if (c == m_lost_clr) m_lost = 1'b0;
    e.lost = m_lost;
    e.err  = (c == m_err_c);
    exp_q.push_back(e);
    @(posedge refclk);
    cyc++;
    #1;
    g = exp_q.pop_front();
    n_checks++;
    if (en_out !== g.en) $display("FAIL sb_en_out cyc=%0d got=%b exp=%b", cyc, en_out, g.en);
    else n_pass++;
    n_checks++;
    if (ready !== g.rdy) $display("FAIL sb_ready cyc=%0d got=%b exp=%b", cyc, ready, g.rdy);
    else n_pass++;
    n_checks++;
    if (lost_lock !== g.lost) $display("FAIL sb_lost_lock cyc=%0d got=%b exp=%b", cyc, lost_lock, g.lost);
    else n_pass++;
    n_checks++;
    if (cfg_err !== g.err) $display("FAIL sb_cfg_err cyc=%0d got=%b exp=%b", cyc, cfg_err, g.err);
    else n_pass++;
  endtask

  task automatic write_cfg(input int ch, input int d, input int p);
    int w;
    w = cyc + 1;
    cfg_wr    = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_div   = 8'(d);
    cfg_phase = 8'(p);
    if (ch < int'(NUM_CH) && (d == 0 || p <= d)) begin
      o_s[ch] = n_s[ch]; o_d[ch] = n_d[ch]; o_p[ch] = n_p[ch];
      n_s[ch] = w; n_d[ch] = d; n_p[ch] = p;
      eff[ch] = w + 1;
    end else begin
      m_err_c = w;
    end
    step();
    cfg_wr = 1'b0;
  endtask

  task automatic raise_lock();
    pll_locked  = 1'b1;
    m_run_start = cyc + 1 + 2 + int'(LOCK_WAIT);
    m_run_stop  = BIG;
  endtask

  task automatic drop_lock();
    int l;
    pll_locked = 1'b0;
    l = cyc + 3;
    if (m_run_start < l && m_run_stop == BIG) begin
      m_run_stop = l;
      m_lost_set = l;
    end else begin
      m_run_start = BIG;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pll_locked = 1'b0; cfg_wr = 1'b0; cfg_ch = '0;
    cfg_div = '0; cfg_phase = '0; lost_clr = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({en_out, ready, lost_lock, cfg_err} !== 6'b0)
      $display("FAIL reset_outputs got=%b exp=000000", {en_out, ready, lost_lock, cfg_err});
    else n_pass++;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_cfg_before_lock();
    write_cfg(0, 3, 0);
    write_cfg(1, 4, 2);
    repeat (2) step();
  endtask

  task automatic test_glitch_restart();
    raise_lock();
    repeat (8) step();
    n_checks++;
    if (ready !== 1'b0) $display("FAIL glitch_ready_early got=%b exp=0", ready);
    else n_pass++;
    drop_lock();
    repeat (3) step();
    raise_lock();
    repeat (2 + int'(LOCK_WAIT) + 1 + 24) step();
    n_checks++;
    if (ready !== 1'b1) $display("FAIL glitch_ready_run got=%b exp=1", ready);
    else n_pass++;
  endtask

  task automatic test_cfg_err();
    write_cfg(0, 2, 5);
    repeat (3) step();
    write_cfg(3, 1, 0);
    repeat (8) step();
  endtask

  task automatic test_back_to_back();
    write_cfg(1, 1, 1);
    write_cfg(2, 2, 0);
    repeat (12) step();
  endtask

  task automatic test_lock_loss();
    drop_lock();
    repeat (5) step();
    n_checks++;
    if ({lost_lock, ready, en_out} !== 5'b10000)
      $display("FAIL loss_state got=%b exp=10000", {lost_lock, ready, en_out});
    else n_pass++;
    lost_clr = 1'b1;
    m_lost_clr = cyc + 1;
    step();
    lost_clr = 1'b0;
    step();
    n_checks++;
    if (lost_lock !== 1'b0) $display("FAIL loss_clear got=%b exp=0", lost_lock);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    raise_lock();
    repeat (2 + int'(LOCK_WAIT) + 1 + 6) step();
    drop_lock();
    repeat (2) step();
    lost_clr = 1'b1;
    m_lost_clr = cyc + 1;
    write_cfg(0, 1, 0);
    lost_clr = 1'b0;
    repeat (4) step();
    n_checks++;
    if (lost_lock !== 1'b1) $display("FAIL simul_set_wins got=%b exp=1", lost_lock);
    else n_pass++;
    lost_clr = 1'b1;
    m_lost_clr = cyc + 1;
    step();
    lost_clr = 1'b0;
    raise_lock();
    repeat (2 + int'(LOCK_WAIT) + 1 + 8) step();
  endtask

  task automatic test_reset_mid_run();
    n_checks++;
    if (ready !== 1'b1) $display("FAIL pre_reset_ready got=%b exp=1", ready);
    else n_pass++;
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({en_out, ready, lost_lock, cfg_err} !== 6'b0)
      $display("FAIL async_reset got=%b exp=000000", {en_out, ready, lost_lock, cfg_err});
    else n_pass++;
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;
    raise_lock();
    repeat (2 + int'(LOCK_WAIT) + 1 + 6) step();
    n_checks++;
    if (ready !== 1'b1) $display("FAIL relock_ready got=%b exp=1", ready);
    else n_pass++;
    write_cfg(0, 1, 0);
    repeat (6) step();
  endtask

  initial begin
    test_reset();
    test_cfg_before_lock();
    test_glitch_restart();
    test_cfg_err();
    test_back_to_back();
    test_lock_loss();
    test_simultaneous();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
